// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch target buffer.
// Tags are stored at the widest size any legal table depth needs.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // The smallest table (4 entries) leaves 28 tag bits above the index.
  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
// Resolved jumps force the counter straight to strong-taken.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  input  logic       force_st_i,
  output logic [1:0] ctr_o
);

  assign ctr_o = force_st_i ? CTR_ST : ctr_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB: combinational IF prediction and EX resolution,
// with the table updated on the clock edge after a valid resolution.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_br_valid_ex,
  input  logic        i_is_jump_ex,
  input  logic [31:0] i_pc_ex,
  input  logic        i_actual_taken_ex,
  input  logic [31:0] i_actual_target_ex,
  input  logic        i_pred_taken_ex,
  input  logic [31:0] i_pred_target_ex,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [31:0]      tgt_q   [BTB_ENTRIES];
  logic [31:0]      br_q, br_d;
  logic [31:0]      miss_q, miss_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_ent;
  logic             if_hit, ex_hit;
  logic [1:0]       ctr_upd, ctr_d;
  logic             ctr_we, ent_we;

  assign if_idx = i_pc_if[IDX_W+1:2];
  assign if_tag = i_pc_if[31:IDX_W+2];
  assign ex_idx = i_pc_ex[IDX_W+1:2];
  assign ex_tag = i_pc_ex[31:IDX_W+2];

  always_comb begin
    if_ent        = '0;
    if_ent.valid  = valid_q[if_idx];
    if_ent.tag    = TAG_MAX_W'(tag_q[if_idx]);
    if_ent.target = tgt_q[if_idx];
    if_ent.ctr    = ctr_q[if_idx];
  end

  assign if_hit        = if_ent.valid && (if_ent.tag == TAG_MAX_W'(if_tag));
  assign o_pred_taken  = if_hit && (if_ent.ctr >= CTR_WT);
  assign o_pred_target = o_pred_taken ? if_ent.target : i_pc_if + 32'd4;

  // Resolution: a bubble in EX must never raise a flush.
  always_comb begin
    o_mispredict  = 1'b0;
    o_redirect_pc = '0;
    if (i_br_valid_ex) begin
      o_mispredict  = (i_pred_taken_ex != i_actual_taken_ex) ||
                      (i_pred_taken_ex && i_actual_taken_ex &&
                       (i_pred_target_ex != i_actual_target_ex));
      o_redirect_pc = i_actual_taken_ex ? i_actual_target_ex : i_pc_ex + 32'd4;
    end
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_ctr (
    .ctr_i      (ctr_q[ex_idx]),
    .taken_i    (i_actual_taken_ex),
    .force_st_i (i_is_jump_ex && i_actual_taken_ex),
    .ctr_o      (ctr_upd)
  );

  // A taken miss allocates; anything else only moves an existing counter.
  always_comb begin
    ent_we = i_br_valid_ex && i_actual_taken_ex;
    ctr_we = i_br_valid_ex && (i_actual_taken_ex || ex_hit);
    ctr_d  = ex_hit ? ctr_upd : (i_is_jump_ex ? CTR_ST : CTR_WT);
  end

  always_comb begin
    br_d   = br_q;
    miss_d = miss_q;
    if (i_br_valid_ex && (br_q != '1))                  br_d   = br_q + 32'd1;
    if (i_br_valid_ex && o_mispredict && (miss_q != '1)) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      if (ctr_we) ctr_q[ex_idx]   <= ctr_d;
      if (ent_we) valid_q[ex_idx] <= 1'b1;
      br_q   <= br_d;
      miss_q <= miss_d;
    end
  end

  // Tag/target carry no reset; an entry is meaningless until its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (ent_we && i_reset) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= i_actual_target_ex;
    end
  end

  assign o_br_count   = br_q;
  assign o_miss_count = miss_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios then random
// traffic, compared against an array-based behavioural model.
module tb_branch_predict_unit;

  localparam int N  = 64;
  localparam int SH = 2 + $clog2(N);

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc_if;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_br_valid_ex, i_is_jump_ex, i_actual_taken_ex, i_pred_taken_ex;
  logic [31:0] i_pc_ex, i_actual_target_ex, i_pred_target_ex;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc, o_br_count, o_miss_count;

  always #5 clk = ~clk;

  branch_predict_unit #(.BTB_ENTRIES(N)) dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_pc_if            (i_pc_if),
    .o_pred_taken       (o_pred_taken),
    .o_pred_target      (o_pred_target),
    .i_br_valid_ex      (i_br_valid_ex),
    .i_is_jump_ex       (i_is_jump_ex),
    .i_pc_ex            (i_pc_ex),
    .i_actual_taken_ex  (i_actual_taken_ex),
    .i_actual_target_ex (i_actual_target_ex),
    .i_pred_taken_ex    (i_pred_taken_ex),
    .i_pred_target_ex   (i_pred_target_ex),
    .o_mispredict       (o_mispredict),
    .o_redirect_pc      (o_redirect_pc),
    .o_br_count         (o_br_count),
    .o_miss_count       (o_miss_count)
  );

  typedef struct {
    bit          pt;
    logic [31:0] ptgt;
    bit          mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
    string       lbl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rst_lvl = 1'b0;

  bit          m_valid [N];
  int unsigned m_tag   [N];
  int unsigned m_tgt   [N];
  int          m_ctr   [N];
  int unsigned m_bc, m_mc;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int idx = int'((pc >> 2) % N);
    bit hit = m_valid[idx] && (m_tag[idx] == (pc >> SH));
    t  = hit && (m_ctr[idx] >= 2);
    tg = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void m_update(input bit brv, jmp, input logic [31:0] pc, input bit at,
                                   input logic [31:0] atgt, input bit mp);
    int idx;
    bit hit;
    if (!brv) return;
    if (m_bc != 32'hFFFF_FFFF) m_bc++;
    if (mp && m_mc != 32'hFFFF_FFFF) m_mc++;
    idx = int'((pc >> 2) % N);
    hit = m_valid[idx] && (m_tag[idx] == (pc >> SH));
    if (at) begin
      if (hit) m_ctr[idx] = jmp ? 3 : ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3);
      else     m_ctr[idx] = jmp ? 3 : 2;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc >> SH;
      m_tgt[idx]   = atgt;
    end else if (hit) begin
      m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
    end
  endfunction

  // One clock of stimulus; the expectation reflects pre-edge table contents.
  task automatic cyc(input logic [31:0] pc_if, input bit brv, input bit jmp,
                     input logic [31:0] pc_ex, input bit at, input logic [31:0] atgt,
                     input bit pt, input logic [31:0] ptgt, input string lbl);
    exp_t e;
    @(posedge clk);
    #1;
    i_reset            = rst_lvl;
    i_pc_if            = pc_if;
    i_br_valid_ex      = brv;
    i_is_jump_ex       = jmp;
    i_pc_ex            = pc_ex;
    i_actual_taken_ex  = at;
    i_actual_target_ex = atgt;
    i_pred_taken_ex    = pt;
    i_pred_target_ex   = ptgt;
    if (!rst_lvl) m_reset();
    m_lookup(pc_if, e.pt, e.ptgt);
    e.mp  = brv && ((pt != at) || (pt && at && (ptgt != atgt)));
    e.rd  = brv ? (at ? atgt : pc_ex + 32'd4) : 32'd0;
    e.bc  = m_bc;
    e.mc  = m_mc;
    e.lbl = lbl;
    q.push_back(e);
    if (rst_lvl) m_update(brv, jmp, pc_ex, at, atgt, e.mp);
  endtask

  task automatic idle(input logic [31:0] pc_if, input string lbl);
    cyc(pc_if, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, lbl);
  endtask

  task automatic resolve(input logic [31:0] pc_if, input bit jmp, input logic [31:0] pc_ex,
                         input bit at, input logic [31:0] atgt, input string lbl);
    bit          pt;
    logic [31:0] ptgt;
    m_lookup(pc_ex, pt, ptgt);
    cyc(pc_if, 1, jmp, pc_ex, at, atgt, pt, ptgt, lbl);
  endtask

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.lbl, "pred_taken",  32'(o_pred_taken), 32'(e.pt));
      chk(e.lbl, "pred_target", o_pred_target,     e.ptgt);
      chk(e.lbl, "mispredict",  32'(o_mispredict), 32'(e.mp));
      chk(e.lbl, "redirect",    o_redirect_pc,     e.rd);
      chk(e.lbl, "br_count",    o_br_count,        e.bc);
      chk(e.lbl, "miss_count",  o_miss_count,      e.mc);
    end
  end

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 7)) << 2)  |  32'($urandom_range(0, 3));
  endfunction

  initial begin
    i_reset = 1'b0; i_pc_if = 32'h100; i_br_valid_ex = 0; i_is_jump_ex = 0;
    i_pc_ex = 0; i_actual_taken_ex = 0; i_actual_target_ex = 0;
    i_pred_taken_ex = 0; i_pred_target_ex = 0;
    m_reset();

    rst_lvl = 1'b0;
    idle(32'h100, "reset");
    idle(32'h100, "reset");
    rst_lvl = 1'b1;
    idle(32'h100, "post_reset");

    cyc(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, "cold_collide");
    idle(32'h100, "cold_lookup");

    resolve(32'h200, 0, 32'h200, 1, 32'h240, "hyst_t1");
    resolve(32'h200, 0, 32'h200, 1, 32'h240, "hyst_t2");
    idle(32'h100, "alias_miss");
    resolve(32'h200, 0, 32'h200, 0, 32'h0, "hyst_nt1");
    idle(32'h200, "hyst_still_t");
    resolve(32'h200, 0, 32'h200, 0, 32'h0, "hyst_nt2");
    idle(32'h200, "hyst_now_nt");

    resolve(32'h300, 1, 32'h300, 1, 32'h400, "jalr_alloc");
    cyc(32'h300, 1, 1, 32'h300, 1, 32'h500, 1, 32'h400, "jalr_tgt_miss");
    idle(32'h300, "jalr_new_tgt");

    cyc(32'h300, 0, 0, 32'h300, 0, 32'h0, 1, 32'h400, "bubble");
    idle(32'h300, "bubble_after");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pce, tgt, pti;
      bit          jmp, at, pt;
      if (i == 200) rst_lvl = 1'b0;
      if (i == 202) rst_lvl = 1'b1;
      pce = rpc();
      jmp = ($urandom_range(0, 4) == 0);
      at  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 1) == 0) ? {24'h0, 6'($urandom_range(0, 63)), 2'b00}
                                        : $urandom;
      m_lookup(pce, pt, pti);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom_range(0, 1));
        pti = $urandom;
      end
      cyc(rpc(), 1'($urandom_range(0, 5) != 0), jmp, pce, at, tgt, pt, pti, "random");
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Branch target buffer with 2-bit saturating direction counters. It predicts next-PC in the IF stage and resolves predictions against actual outcomes in the EX stage. Its `o_mispredict` output is the control-hazard request that drives the hazard/forwarding unit's branch-taken input, which produces the IF/ID and ID/EX flushes. `o_redirect_pc` supplies the PC-mux correction.

## Interface
Parameters:
- `BTB_ENTRIES`, 64, number of direct-mapped entries; power of 2, range 4..1024.
- `IDX_W`, $clog2(BTB_ENTRIES), index width (derived; not overridden).

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pc_if`  in  32  PC of the instruction being fetched.
- `o_pred_taken`  out  1  IF prediction: BTB hit and counter[1]=1.
- `o_pred_target`  out  32  predicted target; equals `i_pc_if+4` when `o_pred_taken`=0.
- `i_br_valid_ex`  in  1  EX holds a valid (non-bubble) branch or jump.
- `i_is_jump_ex`  in  1  EX instruction is JAL/JALR.
- `i_pc_ex`  in  32  PC of the EX instruction.
- `i_actual_taken_ex`  in  1  resolved direction; 1 for jumps.
- `i_actual_target_ex`  in  32  resolved target address.
- `i_pred_taken_ex`  in  1  `o_pred_taken` carried down the pipeline to EX.
- `i_pred_target_ex`  in  32  `o_pred_target` carried down the pipeline to EX.
- `o_mispredict`  out  1  prediction wrong; flush younger stages.
- `o_redirect_pc`  out  32  correct next PC; valid when `o_mispredict`=1.
- `o_br_count`  out  32  resolved branch/jump count.
- `o_miss_count`  out  32  misprediction count.

## Operation
- PC bits [1:0] are ignored. Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
- Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational. Hit = `valid` && tag match. `o_pred_taken` = hit && `ctr[1]`; `o_pred_target` = `target` when predicted taken, else `i_pc_if+4`.
- Resolution is combinational and gated by `i_br_valid_ex`.
  - `o_mispredict` = `i_pred_taken_ex` != `i_actual_taken_ex`, OR (both taken AND `i_pred_target_ex` != `i_actual_target_ex`).
  - `o_redirect_pc` = `i_actual_target_ex` when taken, else `i_pc_ex+4`.
  - When `i_br_valid_ex`=0: `o_mispredict`=0 and `o_redirect_pc`=0.
- Table update occurs at the clock edge when `i_br_valid_ex`=1:
  - Taken and hit: write target; counter saturating-increments (forced to 11 if `i_is_jump_ex`).
  - Taken and miss: allocate by overwriting the entry; set `valid`=1, write tag and target, counter = 10 (11 if jump).
  - Not taken and hit: counter saturating-decrements; target unchanged.
  - Not taken and miss: no write.
- Statistics on each valid resolution: `o_br_count` increments; `o_miss_count` increments when `o_mispredict`=1. Both saturate at 32'hFFFF_FFFF.
- Pipeline bubbles are the caller's responsibility. A flushed or stalled-bubble EX slot must present `i_br_valid_ex`=0.

## Timing
- Prediction has 0-cycle latency: a function of `i_pc_if` and current table state.
- Mispredict and redirect have 0-cycle latency from EX inputs. The hazard unit flushes IF/ID and ID/EX in that same cycle.
- A table write becomes visible to lookup on the cycle after the update edge. When IF lookup and EX update hit the same index in the same cycle, the lookup returns pre-update contents.
- Reset, while `i_reset`=0, asynchronously:
  - all `valid`=0, all `ctr`=01;
  - `o_br_count`=0, `o_miss_count`=0.
  Tag and target arrays are not reset. Outputs follow combinationally: `o_pred_taken`=0, `o_pred_target`=`i_pc_if+4`.
- Reset asserted mid-operation discards any pending update on that edge.
- A counter at 11 stays 11 on taken; a counter at 00 stays 00 on not-taken.

## Structure
- Shared package `bp_pkg`:
  - `btb_entry_t` struct (`valid`, `tag`, `target`, `ctr`);
  - counter constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`;
  - function `ctr_next(ctr, taken)`.
- One sub-module: `sat_counter2`, a pure combinational 2-bit next-state function. It is instantiated once in the update path.
- The table is flop-based: the valid bit needs asynchronous clear and the lookup is asynchronous-read.

## Test plan
- **Reset:** assert `i_reset`=0 mid-run, then release. Lookup at 0x100 gives `o_pred_taken`=0 and `o_pred_target`=0x104; both counters read 0.
- **Cold taken branch:** EX pc=0x100 taken to 0x80 with pred NT gives `o_mispredict`=1 and redirect 0x80. The next cycle, IF pc=0x100 predicts taken to 0x80 (ctr=10).
- **Hysteresis:** train 0x200 strongly taken (two taken resolutions), then one not-taken. The lookup still predicts taken (ctr=10); a second not-taken makes it predict NT.
- **Target mismatch:** a JALR at 0x300 predicted taken to 0x400 resolves to 0x500. Expect `o_mispredict`=1, redirect 0x500, and the stored target updated to 0x500.
- **Aliasing:** with `BTB_ENTRIES`=64, train 0x100, then resolve 0x200 taken (same index, different tag). The lookup at 0x100 misses.
- **Same-cycle collision, bubble and counters:**
  - IF and EX both at 0x100 on the allocation cycle: the lookup returns the old (miss) result.
  - `i_br_valid_ex`=0 with a mismatching pred/actual gives `o_mispredict`=0 and no counter change.
  - Counters show br=N and miss=M after a scripted sequence.
